gate_identifier: RTL and testbench
==================================

GATE_IDENTIFIER -- requirements
Module: gate_identifier

Interface
REQ-001 The block SHALL have exactly one clock and an asynchronous, active-low reset: `clk` and `rst_n`.
REQ-002 `clk`  input  1  rising-edge clock for all state.
REQ-003 `rst_n`  input  1  asynchronous active-low reset.
REQ-004 `start`  input  1  request to identify the gate unit under probe; sampled in IDLE only.
REQ-005 `probe_a`  output  1  registered `a` operand driven to the external gate unit.
REQ-006 `probe_b`  output  1  registered `b` operand driven to the external gate unit.
REQ-007 `probe_result`  input  1  result returned by the external gate unit.
REQ-008 `busy`  output  1  high while a probe sequence or decode is in progress.
REQ-009 `done`  output  1  one-cycle pulse; the results below are valid from this cycle on.
REQ-010 `valid`  output  1  high when the captured truth table matches a known gate code.
REQ-011 `select_out`  output  3  decoded gate select code (000..111).
REQ-012 `negate_out`  output  1  decoded negate_b flag.
REQ-013 `truth_table`  output  4  captured results; bit i holds the result for {a,b}=i.
REQ-014 `unstable`  output  1  double-sample mismatch flag; see Configuration.

Function
REQ-015 FSM states SHALL be IDLE, SETTLE, SAMPLE, DECODE and DONE, with a 2-bit combination index idx.
REQ-016 IDLE with `start`=1 SHALL go to SETTLE, set idx=0 and drive {probe_a,probe_b}=00; otherwise it SHALL stay in IDLE.
REQ-017 SETTLE SHALL hold {probe_a,probe_b}={idx[1],idx[0]} for one cycle and then go to SAMPLE.
REQ-018 On leaving SAMPLE the block SHALL write `probe_result` into truth-table bit idx.
REQ-019 On leaving SAMPLE with idx<3, the block SHALL increment idx, drive the new probe values and go to SETTLE; with idx=3 it SHALL go to DECODE.
REQ-020 Timing, with `start` sampled at edge k: the block SHALL reach DECODE at edge k+8 and DONE at edge k+9, with `done`=1 for exactly one cycle, and SHALL return to IDLE at edge k+10.
REQ-021 `busy` SHALL be 1 exactly in the SETTLE, SAMPLE and DECODE states.
REQ-022 `start` SHALL be ignored in every state other than IDLE, including DONE.
REQ-023 The decode at the DECODE→DONE edge SHALL register these truth-table → {select_out,negate_out} mappings, with `valid`=1:
  - 3→000/0, 0→111/0
  - 8→001/0, 4→001/1
  - 7→010/0, B→010/1
  - E→011/0, D→011/1
  - 1→100/0, 2→100/1
  - 6→101/0, 9→101/1
REQ-024 Truth tables with more than one valid encoding SHALL decode to the lowest {select,negate} value; for example 6 decodes as XOR and not as XNOR with negate.
REQ-025 Truth tables 5, A, C and F SHALL give `valid`=0, `select_out`=000 and `negate_out`=0.
REQ-026 `truth_table`, `valid`, `select_out`, `negate_out` and `unstable` SHALL update only at the DECODE→DONE edge and hold until the next DONE.
REQ-027 `probe_a` and `probe_b` SHALL return to 0 when entering DONE.

Reset
REQ-028 Asserting `rst_n`=0 SHALL immediately, without a clock, force state IDLE and idx=0.
REQ-029 Asserting `rst_n`=0 SHALL clear every output to 0.
REQ-030 Reset asserted mid-sequence SHALL abort the sequence with no `done` pulse; operation SHALL resume on the first `start` after release.

Configuration
REQ-031 The macro `GATE_ID_DOUBLE_SAMPLE_EN` SHALL control double sampling.
REQ-032 With the macro defined:
  - SAMPLE SHALL last two cycles, capturing `probe_result` at both edges.
  - A mismatch for any idx SHALL set `unstable`=1 at DONE and force `valid`=0, `select_out`=000 and `negate_out`=0.
  - The truth table SHALL store the second sample.
  - With `start` at edge k, DONE SHALL be reached at edge k+13.
REQ-033 With the macro undefined, `unstable` SHALL be tied to 0 and the REQ-020 timing SHALL apply.

Verification
REQ-034 DUT output ~a, `start` pulse → `done` at edge k+9, `truth_table`=3, `select_out`=000, `negate_out`=0, `valid`=1.
REQ-035 DUT output a|~b → `truth_table`=D, `select_out`=011, `negate_out`=1, `valid`=1; probes stepped through 00, 01, 10, 11.
REQ-036 DUT output a^b → `truth_table`=6, `select_out`=101, `negate_out`=0; DUT output a xnor b → `truth_table`=9, `select_out`=101, `negate_out`=1.
REQ-037 DUT output constant 1 → `truth_table`=F, `valid`=0, `select_out`=000; `start` pulsed again while `busy` → no restart and exactly one `done`.
REQ-038 `rst_n` pulsed low at edge k+4 → all outputs 0 immediately and no `done`; a new `start` after release → normal result.
REQ-039 With `GATE_ID_DOUBLE_SAMPLE_EN`, DUT output toggling during the idx=2 sample → `unstable`=1, `valid`=0, `done` at edge k+13.

Source files
------------

// File: rtl/gate_identifier.sv
// gate_identifier: probes an external 2-input gate unit with all four operand
// combinations, captures its truth table and decodes it into a gate select
// code plus a negate_b flag.
// Optional build macro GATE_ID_DOUBLE_SAMPLE_EN: each combination is sampled
// on two consecutive edges, and any disagreement is reported on `unstable`.
module gate_identifier (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       probe_a,
  output logic       probe_b,
  input  logic       probe_result,
  output logic       busy,
  output logic       done,
  output logic       valid,
  output logic [2:0] select_out,
  output logic       negate_out,
  output logic [3:0] truth_table,
  output logic       unstable
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETTLE = 3'd1,
    SAMPLE = 3'd2,
    DECODE = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t     state, state_nxt;
  logic [1:0] idx;
  logic [1:0] idx_inc;
  logic [3:0] tt_acc;
  logic       sample_last;

`ifdef GATE_ID_DOUBLE_SAMPLE_EN
  logic       sample_phase;
  logic       first_smp;
  logic       mismatch;
`endif

  // Map a captured truth table to {valid, select, negate}; unknown tables
  // decode to all zeros. Where two encodings fit, the lower one is listed.
  function automatic logic [4:0] decode_gate(input logic [3:0] tt);
    logic [4:0] r;
    case (tt)
      4'h3:    r = {1'b1, 3'b000, 1'b0};
      4'h0:    r = {1'b1, 3'b111, 1'b0};
      4'h8:    r = {1'b1, 3'b001, 1'b0};
      4'h4:    r = {1'b1, 3'b001, 1'b1};
      4'h7:    r = {1'b1, 3'b010, 1'b0};
      4'hB:    r = {1'b1, 3'b010, 1'b1};
      4'hE:    r = {1'b1, 3'b011, 1'b0};
      4'hD:    r = {1'b1, 3'b011, 1'b1};
      4'h1:    r = {1'b1, 3'b100, 1'b0};
      4'h2:    r = {1'b1, 3'b100, 1'b1};
      4'h6:    r = {1'b1, 3'b101, 1'b0};
      4'h9:    r = {1'b1, 3'b101, 1'b1};
      default: r = 5'b0;
    endcase
    return r;
  endfunction

  assign idx_inc = idx + 2'd1;

`ifdef GATE_ID_DOUBLE_SAMPLE_EN
  assign sample_last = sample_phase;
`else
  assign sample_last = 1'b1;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state and status outputs
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE:   if (start) state_nxt = SETTLE;
      SETTLE: begin
        busy      = 1'b1;
        state_nxt = SAMPLE;
      end
      SAMPLE: begin
        busy = 1'b1;
        if (sample_last) state_nxt = (idx == 2'd3) ? DECODE : SETTLE;
      end
      DECODE: begin
        busy      = 1'b1;
        state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Probe drive, truth-table capture and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx         <= 2'd0;
      probe_a     <= 1'b0;
      probe_b     <= 1'b0;
      tt_acc      <= 4'd0;
      valid       <= 1'b0;
      select_out  <= 3'd0;
      negate_out  <= 1'b0;
      truth_table <= 4'd0;
`ifdef GATE_ID_DOUBLE_SAMPLE_EN
      sample_phase <= 1'b0;
      first_smp    <= 1'b0;
      mismatch     <= 1'b0;
      unstable     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (start) begin
          idx     <= 2'd0;
          probe_a <= 1'b0;
          probe_b <= 1'b0;
          tt_acc  <= 4'd0;
`ifdef GATE_ID_DOUBLE_SAMPLE_EN
          sample_phase <= 1'b0;
          mismatch     <= 1'b0;
`endif
        end
        SAMPLE: begin
`ifdef GATE_ID_DOUBLE_SAMPLE_EN
          sample_phase <= ~sample_phase;
          if (!sample_phase) first_smp <= probe_result;
          else if (probe_result != first_smp) mismatch <= 1'b1;
`endif
          if (sample_last) begin
            tt_acc[idx] <= probe_result;
            if (idx != 2'd3) begin
              idx                <= idx_inc;
              {probe_a, probe_b} <= idx_inc;
            end
          end
        end
        DECODE: begin
          probe_a     <= 1'b0;
          probe_b     <= 1'b0;
          truth_table <= tt_acc;
`ifdef GATE_ID_DOUBLE_SAMPLE_EN
          unstable <= mismatch;
          if (mismatch) {valid, select_out, negate_out} <= 5'b0;
          else          {valid, select_out, negate_out} <= decode_gate(tt_acc);
`else
          {valid, select_out, negate_out} <= decode_gate(tt_acc);
`endif
        end
        default: ;
      endcase
    end
  end

`ifndef GATE_ID_DOUBLE_SAMPLE_EN
  assign unstable = 1'b0;
`endif

endmodule

// File: tb/tb_gate_identifier.sv
// Testbench for gate_identifier: a behavioural gate unit answers the probes,
// a vector table covers all sixteen truth tables, and hand-written sequences
// cover restart attempts, mid-sequence reset and (when built with
// GATE_ID_DOUBLE_SAMPLE_EN) an unstable gate.
module tb_gate_identifier;

`ifdef GATE_ID_DOUBLE_SAMPLE_EN
  localparam int LAT = 13;
`else
  localparam int LAT = 9;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       probe_a, probe_b, probe_result;
  logic       busy, done, valid, negate_out, unstable;
  logic [2:0] select_out;
  logic [3:0] truth_table;

  logic [3:0] gate_tt = 4'h0;
  logic       tog_en = 1'b0;
  logic       flip = 1'b0;
  int         done_cnt = 0;
  int         n_chk = 0;
  int         n_fail = 0;

  typedef struct {
    logic [3:0] gate;
    logic       v;
    logic [2:0] sel;
    logic       neg;
  } vec_t;

  typedef struct {
    logic [3:0] tt;
    logic       v;
    logic [2:0] sel;
    logic       neg;
    logic       uns;
    bit         chk_tt;
  } exp_t;

  vec_t vecs[16];
  exp_t exp_q[$];
  logic [1:0] seq[$];

  gate_identifier dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .probe_a(probe_a), .probe_b(probe_b), .probe_result(probe_result),
    .busy(busy), .done(done), .valid(valid), .select_out(select_out),
    .negate_out(negate_out), .truth_table(truth_table), .unstable(unstable)
  );

  always #5 clk = ~clk;

  // External gate unit, with an optional glitch on the a=1,b=0 combination
  assign probe_result = gate_tt[{probe_a, probe_b}] ^ (tog_en & probe_a & ~probe_b & flip);

  always @(negedge clk) begin
    flip <= ~flip;
    if (done) done_cnt <= done_cnt + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_gate(input logic [3:0] g, input exp_t e, input bit restart,
                          input bit check_probes);
    int   cyc;
    int   d0;
    bit   got;
    exp_t x;
    gate_tt = g;
    exp_q.push_back(e);
    seq.delete();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    d0  = done_cnt;
    cyc = 0;
    got = 0;
    while (cyc < 40 && !got) begin
      if (busy && (seq.size() == 0 || seq[$] != {probe_a, probe_b}))
        seq.push_back({probe_a, probe_b});
      start = restart && (cyc == 3);
      @(posedge clk);
      #1;
      cyc++;
      if (done) got = 1;
    end
    start = 1'b0;
    if (!got) begin
      n_chk++;
      n_fail++;
      $display("FAIL done_timeout: got no done expected done within 40 cycles");
      void'(exp_q.pop_front());
      return;
    end
    x = exp_q.pop_front();
    chk("done_latency", cyc, LAT);
    if (x.chk_tt) chk("truth_table", truth_table, x.tt);
    chk("valid", valid, x.v);
    chk("select_out", select_out, x.sel);
    chk("negate_out", negate_out, x.neg);
    chk("unstable", unstable, x.uns);
    chk("probes_at_done", {probe_a, probe_b}, 0);
    chk("busy_at_done", busy, 0);
    if (check_probes) begin
      chk("probe_steps", seq.size(), 4);
      if (seq.size() == 4) begin
        for (int i = 0; i < 4; i++) chk("probe_value", seq[i], i);
      end
    end
    if (restart) start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("done_one_cycle", done, 0);
    chk("idle_after_done", busy, 0);
    if (restart) begin
      repeat (20) @(posedge clk);
      #1;
      chk("single_done", done_cnt - d0, 1);
      chk("no_restart_busy", busy, 0);
    end
  endtask

  initial begin
    exp_t e;
    int   d0;
    vecs[0]  = '{4'h0, 1'b1, 3'b111, 1'b0};
    vecs[1]  = '{4'h1, 1'b1, 3'b100, 1'b0};
    vecs[2]  = '{4'h2, 1'b1, 3'b100, 1'b1};
    vecs[3]  = '{4'h3, 1'b1, 3'b000, 1'b0};
    vecs[4]  = '{4'h4, 1'b1, 3'b001, 1'b1};
    vecs[5]  = '{4'h5, 1'b0, 3'b000, 1'b0};
    vecs[6]  = '{4'h6, 1'b1, 3'b101, 1'b0};
    vecs[7]  = '{4'h7, 1'b1, 3'b010, 1'b0};
    vecs[8]  = '{4'h8, 1'b1, 3'b001, 1'b0};
    vecs[9]  = '{4'h9, 1'b1, 3'b101, 1'b1};
    vecs[10] = '{4'hA, 1'b0, 3'b000, 1'b0};
    vecs[11] = '{4'hB, 1'b1, 3'b010, 1'b1};
    vecs[12] = '{4'hC, 1'b0, 3'b000, 1'b0};
    vecs[13] = '{4'hD, 1'b1, 3'b011, 1'b1};
    vecs[14] = '{4'hE, 1'b1, 3'b011, 1'b0};
    vecs[15] = '{4'hF, 1'b0, 3'b000, 1'b0};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs",
        {probe_a, probe_b, busy, done, valid, select_out, negate_out, truth_table, unstable}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("idle_no_start", busy, 0);

    // ~a with probe stepping, then every truth table
    e = '{4'h3, 1'b1, 3'b000, 1'b0, 1'b0, 1'b1};
    run_gate(4'h3, e, 0, 1);
    for (int i = 0; i < 16; i++) begin
      e = '{vecs[i].gate, vecs[i].v, vecs[i].sel, vecs[i].neg, 1'b0, 1'b1};
      run_gate(vecs[i].gate, e, 0, i == 13);
    end

    // Constant 1 with start pulsed while busy and while in DONE
    e = '{4'hF, 1'b0, 3'b000, 1'b0, 1'b0, 1'b1};
    run_gate(4'hF, e, 1, 0);

    // Reset in the middle of a sequence
    gate_tt = 4'h6;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    d0 = done_cnt;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("reset_mid_outputs",
        {probe_a, probe_b, busy, done, valid, select_out, negate_out, truth_table, unstable}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("no_done_after_abort", done_cnt - d0, 0);
    chk("idle_after_abort", busy, 0);
    e = '{4'h9, 1'b1, 3'b101, 1'b1, 1'b0, 1'b1};
    run_gate(4'h9, e, 0, 0);

`ifdef GATE_ID_DOUBLE_SAMPLE_EN
    // Gate output toggling while the a=1,b=0 combination is sampled
    tog_en = 1'b1;
    e = '{4'h6, 1'b0, 3'b000, 1'b0, 1'b1, 1'b0};
    run_gate(4'h6, e, 0, 0);
    tog_en = 1'b0;
    e = '{4'h6, 1'b1, 3'b101, 1'b0, 1'b0, 1'b1};
    run_gate(4'h6, e, 0, 0);
`endif

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
